atpg_bist_ctrl: RTL
===================

ATPG_BIST_CTRL -- requirements
Module: atpg_bist_ctrl

Interface
REQ-001 Parameter: W, default 5, width of seed, pattern, response, MISR and golden signature.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request one test session; acted on only in IDLE.
REQ-005 abort  input  1  terminate the session in progress.
REQ-006 seed_in  input  W  generator seed, sampled with start.
REQ-007 pat_count  input  W  number of patterns, sampled with start; 0 means 2^W.
REQ-008 golden  input  W  expected signature, sampled with start.
REQ-009 cut_resp  input  W  circuit-under-test response, valid one cycle after each pattern_en cycle.
REQ-010 seed_load  output  1  one-cycle load strobe to the LFSR pattern generator.
REQ-011 seed_out  output  W  seed driven to the generator, valid while seed_load=1.
REQ-012 pattern_en  output  1  generator advance enable; one pattern per high cycle.
REQ-013 busy  output  1  session in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 pass  output  1  session verdict, held until next accepted start.
REQ-016 signature  output  W  current MISR contents.

Function
REQ-017 FSM states SHALL be IDLE, SEED, RUN, FLUSH, DONE; encoding free.
REQ-018 IDLE: start=1 at an edge SHALL latch seed_in, pat_count, golden, clear MISR and pass, go to SEED.
REQ-019 SEED (one cycle): seed_load=1; seed_out=latched seed, except seed 0 SHALL be replaced by 1 (all-zero LFSR lock-up).
REQ-020 RUN: pattern_en=1 every cycle; pattern counter (W+1 bits) counts applied patterns; after exactly N patterns (N=pat_count, or 2^W if 0) go to FLUSH.
REQ-021 cap_en SHALL be pattern_en delayed one cycle; MISR updates only when cap_en=1.
REQ-022 MISR update: fb = m[W-1] ^ m[1]; m_next = {m[W-2:0], fb} XOR cut_resp.
REQ-023 FLUSH (one cycle): pattern_en=0; captures the final response via cap_en.
REQ-024 DONE (one cycle): done=1; pass registered as (MISR == latched golden); next state IDLE.
REQ-025 Latency: start accepted at edge k -> seed_load high cycle k+1, pattern_en high cycles k+2..k+N+1, done high cycle k+N+3.
REQ-026 busy=1 in SEED, RUN, FLUSH, DONE; 0 in IDLE.
REQ-027 start while busy SHALL be ignored; inputs not re-sampled.
REQ-028 abort=1 in any non-IDLE state SHALL go to IDLE next edge: no done pulse, pass=0, MISR holds; abort has priority over all transitions.
REQ-029 start and abort simultaneous in IDLE: abort wins, start ignored.
REQ-030 seed_load, pattern_en, done SHALL be registered (glitch-free) outputs.

Reset
REQ-031 rst=0 SHALL immediately force state IDLE, MISR 0, counter 0, cap_en 0, and all outputs 0 (seed_out 0).
REQ-032 Reset asserted mid-session SHALL abandon it with no done pulse; first start after release begins a fresh session.

Verification
REQ-033 Reset release, idle 5 cycles -> all outputs 0, busy 0.
REQ-034 seed_in=10101, pat_count=5, cut_resp=0, golden=0, start pulse -> seed_load 1 cycle with seed_out=10101, pattern_en exactly 5 cycles, done 1 cycle, pass=1, signature=0.
REQ-035 pat_count=1, cut_resp=00001, golden=00001 -> signature=00001, pass=1; same with golden=00010 -> pass=0.
REQ-036 seed_in=0, pat_count=0 -> seed_out=00001, pattern_en exactly 32 cycles, done at start edge +35.
REQ-037 abort asserted on 3rd RUN cycle of pat_count=10 -> IDLE next cycle, busy 0, no done, pass 0; start while busy earlier ignored.
REQ-038 rst=0 pulsed mid-RUN (asynchronously, between edges) -> outputs 0 immediately; subsequent start runs full session normally.

Source files
------------

// File: rtl/atpg_bist_ctrl.sv
// Logic-BIST session controller: seeds an LFSR pattern generator, runs N patterns,
// compacts circuit responses in a MISR and reports a pass/fail verdict.
module atpg_bist_ctrl #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] seed_in,
  input  logic [W-1:0] pat_count,
  input  logic [W-1:0] golden,
  input  logic [W-1:0] cut_resp,
  output logic         seed_load,
  output logic [W-1:0] seed_out,
  output logic         pattern_en,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [W-1:0] signature
);

  typedef enum logic [2:0] {S_IDLE, S_SEED, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] seed_q, seed_d;
  logic [W-1:0] golden_q, golden_d;
  logic [W:0]   n_q, n_d;
  logic [W:0]   cnt_q, cnt_d;
  logic [W-1:0] misr_q, misr_d;
  logic         cap_en_q, cap_en_d;
  logic         seed_load_q, seed_load_d;
  logic [W-1:0] seed_out_q, seed_out_d;
  logic         pattern_en_q, pattern_en_d;
  logic         done_q, done_d;
  logic         pass_q, pass_d;
  logic [W-1:0] misr_upd;

  assign misr_upd = {misr_q[W-2:0], misr_q[W-1] ^ misr_q[1]} ^ cut_resp;

  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    golden_d = golden_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    misr_d   = misr_q;
    pass_d   = pass_q;
    cap_en_d = pattern_en_q;

    // Responses trail pattern_en by one cycle; cap_en lines the MISR up with them.
    if (cap_en_q && state_q != S_IDLE) misr_d = misr_upd;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          seed_d   = seed_in;
          golden_d = golden;
          n_d      = (pat_count == '0) ? {1'b1, {W{1'b0}}} : {1'b0, pat_count};
          cnt_d    = '0;
          misr_d   = '0;
          pass_d   = 1'b0;
          state_d  = S_SEED;
        end
      end
      S_SEED: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + (W+1)'(1);
        if (cnt_d == n_q) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        state_d = S_DONE;
        pass_d  = (misr_d == golden_q);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort freezes the signature and suppresses the verdict.
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      misr_d   = misr_q;
      pass_d   = 1'b0;
      cap_en_d = 1'b0;
    end

    // Strobes come from the next state so they leave the flops glitch-free.
    seed_load_d  = (state_d == S_SEED);
    seed_out_d   = '0;
    if (state_d == S_SEED) seed_out_d = (seed_d == '0) ? W'(1) : seed_d;
    pattern_en_d = (state_d == S_RUN);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      seed_q       <= '0;
      golden_q     <= '0;
      n_q          <= '0;
      cnt_q        <= '0;
      misr_q       <= '0;
      cap_en_q     <= 1'b0;
      seed_load_q  <= 1'b0;
      seed_out_q   <= '0;
      pattern_en_q <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      seed_q       <= seed_d;
      golden_q     <= golden_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      misr_q       <= misr_d;
      cap_en_q     <= cap_en_d;
      seed_load_q  <= seed_load_d;
      seed_out_q   <= seed_out_d;
      pattern_en_q <= pattern_en_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign seed_load  = seed_load_q;
  assign seed_out   = seed_out_q;
  assign pattern_en = pattern_en_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign signature  = misr_q;
  assign busy       = (state_q != S_IDLE);

endmodule
